// File: rtl/ysyx_23060062_exu_pkg.sv
// rtl/ysyx_23060062_exu_pkg.sv - shared constants and types for the execute-stage controller
//
// Contents:
//   OPC_*         5-bit major opcodes (inst[6:2])
//   TYPE_*        alu_type encodings for the instruction formats R..J
//   state_t       controller state enum
//   FUNCT7_MULDIV funct7 marking the RV32M group
//   ADD_*         ALU drive used for the shift-add multiply loop
//   writes_rd()   opcodes that retire a register write

package ysyx_23060062_exu_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [31:0] ADD_EN        = 32'h0000_1000;
  localparam logic [7:0]  ADD_FUNCT3_EN = 8'h01;
  localparam logic [6:0]  ADD_FUNCT7    = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ALU  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic writes_rd(input logic [4:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) ||
           (opc == OPC_LUI) || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/ysyx_23060062_exu_decode.sv
// rtl/ysyx_23060062_exu_decode.sv - combinational instruction decode for the execute controller
//
// Ports:
//   inst       in  32  raw instruction word
//   en         out 32  one-hot opcode enable (bit inst[6:2]), 0 when illegal
//   inst_type  out 3   format encoding TYPE_R..TYPE_J
//   funct3_en  out 8   one-hot funct3 for R/I/S/B formats, else 0
//   funct7     out 7   funct7 for OP and OP-IMM shifts, else 0
//   is_mul     out 1   legal RV32M MUL
//   illegal    out 1   compressed, unknown opcode, or unsupported M op

module ysyx_23060062_exu_decode
  import ysyx_23060062_exu_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] en,
  output logic [2:0]  inst_type,
  output logic [7:0]  funct3_en,
  output logic [6:0]  funct7,
  output logic        is_mul,
  output logic        illegal
);

  logic [4:0] opc;
  logic [2:0] f3;
  logic       known;
  logic       is_muldiv;

  // rd and rs fields are carried separately by the pipeline
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  assign opc = inst[6:2];
  assign f3  = inst[14:12];

  always_comb begin
    known     = 1'b1;
    inst_type = TYPE_R;
    case (opc)
      OPC_OP:                          inst_type = TYPE_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:  inst_type = TYPE_I;
      OPC_STORE:                       inst_type = TYPE_S;
      OPC_BRANCH:                      inst_type = TYPE_B;
      OPC_LUI, OPC_AUIPC:              inst_type = TYPE_U;
      OPC_JAL:                         inst_type = TYPE_J;
      default:                         known     = 1'b0;
    endcase

    is_muldiv = (opc == OPC_OP) && (inst[31:25] == FUNCT7_MULDIV);
    illegal   = (inst[1:0] != 2'b11) || !known || (is_muldiv && (f3 != 3'b000));
    is_mul    = !illegal && is_muldiv;

    en        = illegal ? 32'd0 : (32'd1 << opc);
    funct3_en = (!illegal && (inst_type <= TYPE_B)) ? (8'd1 << f3) : 8'd0;
    // Immediate shifts reuse funct7 to distinguish SRLI/SRAI
    funct7    = (!illegal && ((opc == OPC_OP) ||
                 ((opc == OPC_OP_IMM) && ((f3 == 3'b001) || (f3 == 3'b101)))))
                ? inst[31:25] : 7'd0;
  end

endmodule

// File: rtl/ysyx_23060062_exu_ctrl.sv
// rtl/ysyx_23060062_exu_ctrl.sv - execute-stage controller driving the shared RV32 ALU
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                decode handshake
//   in_inst, in_src1, in_src2        instruction and resolved operands
//   in_rd_addr                       destination register
//   alu_en/type/funct3_en/funct7     ALU control (all zero when idle)
//   alu_src1, alu_src2, alu_rd       ALU operands and combinational result
//   out_valid/out_ready              writeback handshake
//   out_data, out_rd_addr            result and destination
//   out_wen, out_illegal             register write required / instruction rejected

module ysyx_23060062_exu_ctrl
  import ysyx_23060062_exu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [4:0]  in_rd_addr,
  output logic [31:0] alu_en,
  output logic [2:0]  alu_type,
  output logic [7:0]  alu_funct3_en,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd_addr,
  output logic        out_wen,
  output logic        out_illegal
);

  state_t      state_q, state_nxt;
  logic [31:0] inst_q, src1_q, src2_q;
  logic [31:0] acc, mcand, mplier;
  logic [4:0]  cnt;
  logic        accept;
  logic        rd_write;

  logic [31:0] dec_inst;
  logic [31:0] dec_en;
  logic [2:0]  dec_type;
  logic [7:0]  dec_funct3_en;
  logic [6:0]  dec_funct7;
  logic        dec_is_mul;
  logic        dec_illegal;

  // One decoder serves both uses: the incoming word while accepting,
  // the latched word while the ALU state drives its fields.
  assign dec_inst = (state_q == ST_ALU) ? inst_q : in_inst;

  ysyx_23060062_exu_decode u_decode (
    .inst      (dec_inst),
    .en        (dec_en),
    .inst_type (dec_type),
    .funct3_en (dec_funct3_en),
    .funct7    (dec_funct7),
    .is_mul    (dec_is_mul),
    .illegal   (dec_illegal)
  );

  assign out_valid = (state_q == ST_DONE);
  // Only legal instructions reach ALU/MUL, so legality is implied here
  assign rd_write  = writes_rd(inst_q[6:2]) && (out_rd_addr != 5'd0);

  always_comb begin
    in_ready      = 1'b0;
    state_nxt     = state_q;
    alu_en        = 32'd0;
    alu_type      = 3'd0;
    alu_funct3_en = 8'd0;
    alu_funct7    = 7'd0;
    alu_src1      = 32'd0;
    alu_src2      = 32'd0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        in_ready = (state_q == ST_IDLE) || out_ready;
        if ((state_q == ST_DONE) && out_ready) state_nxt = ST_IDLE;
        if (in_valid && in_ready) begin
          if (dec_illegal)     state_nxt = ST_DONE;
          else if (dec_is_mul) state_nxt = ST_MUL;
          else                 state_nxt = ST_ALU;
        end
      end
      ST_ALU: begin
        alu_en        = dec_en;
        alu_type      = dec_type;
        alu_funct3_en = dec_funct3_en;
        alu_funct7    = dec_funct7;
        alu_src1      = src1_q;
        alu_src2      = src2_q;
        state_nxt     = ST_DONE;
      end
      ST_MUL: begin
        // Shift-add: one partial product accumulated per cycle on the adder
        alu_en        = ADD_EN;
        alu_type      = TYPE_R;
        alu_funct3_en = ADD_FUNCT3_EN;
        alu_funct7    = ADD_FUNCT7;
        alu_src1      = acc;
        alu_src2      = mplier[0] ? mcand : 32'd0;
        if (cnt == 5'd31) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      inst_q      <= 32'd0;
      src1_q      <= 32'd0;
      src2_q      <= 32'd0;
      acc         <= 32'd0;
      mcand       <= 32'd0;
      mplier      <= 32'd0;
      cnt         <= 5'd0;
      out_data    <= 32'd0;
      out_rd_addr <= 5'd0;
      out_wen     <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        inst_q      <= in_inst;
        src1_q      <= in_src1;
        src2_q      <= in_src2;
        out_rd_addr <= in_rd_addr;
        acc         <= 32'd0;
        mcand       <= in_src1;
        mplier      <= in_src2;
        cnt         <= 5'd0;
        if (dec_illegal) begin
          out_data    <= 32'd0;
          out_wen     <= 1'b0;
          out_illegal <= 1'b1;
        end
      end
      case (state_q)
        ST_ALU: begin
          out_data    <= alu_rd;
          out_wen     <= rd_write;
          out_illegal <= 1'b0;
        end
        ST_MUL: begin
          acc    <= alu_rd;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            out_data    <= alu_rd;
            out_wen     <= rd_write;
            out_illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060062_exu_ctrl.sv
// tb/tb_ysyx_23060062_exu_ctrl.sv - self-checking bench for the execute-stage controller

module tb_ysyx_23060062_exu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst, in_src1, in_src2;
  logic [4:0]  in_rd_addr;
  logic [31:0] alu_en;
  logic [2:0]  alu_type;
  logic [7:0]  alu_funct3_en;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_src1, alu_src2, alu_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd_addr;
  logic        out_wen, out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060062_exu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_src1(in_src1), .in_src2(in_src2), .in_rd_addr(in_rd_addr),
    .alu_en(alu_en), .alu_type(alu_type), .alu_funct3_en(alu_funct3_en),
    .alu_funct7(alu_funct7), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_rd(alu_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd_addr(out_rd_addr), .out_wen(out_wen), .out_illegal(out_illegal)
  );

  // Stand-in for the shared ALU, driven purely from the one-hot controls
  always_comb begin
    alu_rd = 32'd0;
    if (alu_en[12] || alu_en[4]) begin
      case (alu_funct3_en)
        8'h01: alu_rd = (alu_en[12] && alu_funct7[5]) ? alu_src1 - alu_src2 : alu_src1 + alu_src2;
        8'h02: alu_rd = alu_src1 << alu_src2[4:0];
        8'h04: alu_rd = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
        8'h08: alu_rd = {31'd0, alu_src1 < alu_src2};
        8'h10: alu_rd = alu_src1 ^ alu_src2;
        8'h20: alu_rd = alu_funct7[5] ? 32'($signed(alu_src1) >>> alu_src2[4:0])
                                      : alu_src1 >> alu_src2[4:0];
        8'h40: alu_rd = alu_src1 | alu_src2;
        8'h80: alu_rd = alu_src1 & alu_src2;
        default: alu_rd = 32'hDEAD_BEEF;
      endcase
    end else if (alu_en[13]) alu_rd = alu_src2;
    else if (alu_en[24])     alu_rd = alu_src1 - alu_src2;
    else if (alu_en != 0)    alu_rd = alu_src1 + alu_src2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: result, write enable, legality, latency and format
  function automatic void ref_model(input logic [31:0] inst, input logic [31:0] a, b,
                                    input logic [4:0] rd, output logic [31:0] data,
                                    output logic wen, output logic ill, output int lat,
                                    output logic [2:0] typ);
    logic [4:0] op;
    logic [2:0] f3;
    logic       known;
    op = inst[6:2];
    f3 = inst[14:12];
    known = 1'b1;
    typ = 3'd0;
    case (op)
      5'b01100: typ = 3'd0;
      5'b00100, 5'b00000, 5'b11001: typ = 3'd1;
      5'b01000: typ = 3'd2;
      5'b11000: typ = 3'd3;
      5'b01101, 5'b00101: typ = 3'd4;
      5'b11011: typ = 3'd5;
      default: known = 1'b0;
    endcase
    ill = (inst[1:0] != 2'b11) || !known || (op == 5'b01100 && inst[31:25] == 7'd1 && f3 != 0);
    data = 32'd0;
    lat  = 1;
    if (!ill) begin
      lat = 2;
      if (op == 5'b01100 && inst[31:25] == 7'd1) begin
        data = a * b;
        lat  = 33;
      end else if (op == 5'b01100 || op == 5'b00100) begin
        case (f3)
          3'd0: data = (op == 5'b01100 && inst[30]) ? a - b : a + b;
          3'd1: data = a << b[4:0];
          3'd2: data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: data = (a < b) ? 32'd1 : 32'd0;
          3'd4: data = a ^ b;
          3'd5: data = inst[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: data = a | b;
          default: data = a & b;
        endcase
      end else if (op == 5'b01101) data = b;
      else if (op == 5'b11000)     data = a - b;
      else                         data = a + b;
    end
    wen = !ill && (op == 5'b01100 || op == 5'b00100 || op == 5'b01101 || op == 5'b00101) && rd != 0;
  endfunction

  // Issue from IDLE, check ALU drive in cycle 1, latency, result, then retire
  task automatic run_op(input logic [31:0] inst, a, b, input logic [4:0] rd,
                        input logic [31:0] e_data, input logic e_wen, e_ill,
                        input int e_lat, input logic [2:0] e_typ);
    int cyc;
    logic mul;
    logic [2:0] f3;
    logic [4:0] op;
    op  = inst[6:2];
    f3  = inst[14:12];
    mul = !e_ill && op == 5'b01100 && inst[31:25] == 7'd1;
    in_inst = inst; in_src1 = a; in_src2 = b; in_rd_addr = rd; in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!e_ill) begin
      if (mul) begin
        chk("mul_en", alu_en, 32'h1000);
        chk("mul_type", {29'd0, alu_type}, 32'd0);
        chk("mul_f3en", {24'd0, alu_funct3_en}, 32'h01);
        chk("mul_src1", alu_src1, 32'd0);
        chk("mul_src2", alu_src2, b[0] ? a : 32'd0);
      end else begin
        chk("alu_en", alu_en, 32'd1 << op);
        chk("alu_type", {29'd0, alu_type}, {29'd0, e_typ});
        chk("alu_f3en", {24'd0, alu_funct3_en}, (e_typ <= 3) ? (32'd1 << f3) : 32'd0);
        chk("alu_f7", {25'd0, alu_funct7},
            (op == 5'b01100 || (op == 5'b00100 && (f3 == 1 || f3 == 5))) ? {25'd0, inst[31:25]} : 32'd0);
        chk("alu_src", alu_src1 ^ {alu_src2[15:0], alu_src2[31:16]}, a ^ {b[15:0], b[31:16]});
      end
    end
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, e_lat);
    chk("out_data", out_data, e_data);
    chk("out_rd", {27'd0, out_rd_addr}, {27'd0, rd});
    chk("out_wen", {31'd0, out_wen}, {31'd0, e_wen});
    chk("out_illegal", {31'd0, out_illegal}, {31'd0, e_ill});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("retired", {31'd0, out_valid}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] inst, a, b;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen, ill;
    int          lat;
    logic [2:0]  typ;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] inst, a, b, e_data;
    logic [4:0]  rd, op;
    logic        e_wen, e_ill;
    int          e_lat, k;
    logic [2:0]  e_typ;
    logic [4:0]  legal_ops[9];

    legal_ops = '{5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000,
                  5'b11000, 5'b01101, 5'b00101, 5'b11011};
    vecs[0] = '{32'h002081B3, 32'd5, 32'd7, 5'd3, 32'd12, 1'b1, 1'b0, 2, 3'd0};
    vecs[1] = '{32'h022082B3, 32'hFFFFFFFF, 32'd3, 5'd5, 32'hFFFFFFFD, 1'b1, 1'b0, 33, 3'd0};
    vecs[2] = '{32'h022092B3, 32'd1, 32'd2, 5'd5, 32'd0, 1'b0, 1'b1, 1, 3'd0};
    vecs[3] = '{32'h00004501, 32'd1, 32'd2, 5'd10, 32'd0, 1'b0, 1'b1, 1, 3'd0};
    vecs[4] = '{32'h00208033, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0, 1'b0, 2, 3'd0};
    vecs[5] = '{32'h0020A023, 32'h100, 32'h20, 5'd4, 32'h120, 1'b0, 1'b0, 2, 3'd2};
    vecs[6] = '{32'h402081B3, 32'd5, 32'd7, 5'd3, 32'hFFFFFFFE, 1'b1, 1'b0, 2, 3'd0};
    vecs[7] = '{32'h123450B7, 32'd0, 32'h12345000, 5'd1, 32'h12345000, 1'b1, 1'b0, 2, 3'd4};
    vecs[8] = '{32'h00208063, 32'd9, 32'd4, 5'd0, 32'd5, 1'b0, 1'b0, 2, 3'd3};
    vecs[9] = '{32'h4040D093, 32'h80000000, 32'd4, 5'd1, 32'hF8000000, 1'b1, 1'b0, 2, 3'd1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_src1 = 32'd0; in_src2 = 32'd0; in_rd_addr = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_en", alu_en, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flags", {29'd0, out_wen, out_illegal, |out_rd_addr}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].data,
             vecs[i].wen, vecs[i].ill, vecs[i].lat, vecs[i].typ);

    // Backpressure, then retire and accept on one edge
    in_inst = 32'h002081B3; in_src1 = 32'd5; in_src2 = 32'd7; in_rd_addr = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", out_data, 32'd12);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_inst = 32'h40208333; in_src1 = 32'd10; in_src2 = 32'd3; in_rd_addr = 5'd6;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("overlap_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("overlap_retired", {31'd0, out_valid}, 32'd0);
    chk("overlap_alu_en", alu_en, 32'h1000);
    chk("overlap_src1", alu_src1, 32'd10);
    @(posedge clk); #1;
    chk("overlap_valid", {31'd0, out_valid}, 32'd1);
    chk("overlap_data", out_data, 32'd7);
    chk("overlap_rd", {27'd0, out_rd_addr}, 32'd6);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during MUL cycle 10
    in_inst = 32'h022082B3; in_src1 = 32'd7; in_src2 = 32'd6; in_rd_addr = 5'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_mul_en", alu_en, 32'h1000);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_alu", alu_en | alu_src1 | alu_src2, 32'd0);
    chk("abort_out", out_data | {27'd0, out_rd_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h002081B3, 32'd20, 32'd22, 5'd3, 32'd42, 1'b1, 1'b0, 2, 3'd0);

    // Randomized instructions against the reference model
    for (int n = 0; n < 60; n++) begin
      inst = $urandom;
      a    = $urandom;
      b    = (n % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rd   = 5'($urandom_range(0, 31));
      k    = $urandom_range(0, 12);
      inst[1:0] = 2'b11;
      if (k < 9) begin
        inst[6:2] = legal_ops[k];
        if (legal_ops[k] == 5'b01100 && inst[31:25] == 7'd1) inst[31:25] = 7'd0;
      end else if (k == 9) begin
        inst[6:2] = 5'b01100; inst[31:25] = 7'd1; inst[14:12] = 3'd0;
      end else if (k == 10) begin
        inst[6:2] = 5'b01100; inst[31:25] = 7'd1; inst[14:12] = 3'($urandom_range(1, 7));
      end else if (k == 11) begin
        do op = 5'($urandom_range(0, 31));
        while (op inside {5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000,
                          5'b11000, 5'b01101, 5'b00101, 5'b11011});
        inst[6:2] = op;
      end else begin
        inst[1:0] = 2'($urandom_range(0, 2));
      end
      ref_model(inst, a, b, rd, e_data, e_wen, e_ill, e_lat, e_typ);
      run_op(inst, a, b, rd, e_data, e_wen, e_ill, e_lat, e_typ);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060062_exu_ctrl.md
# ysyx_23060062_exu_ctrl

Execute-stage controller that sits between the decode stage and the shared RV32 ALU. It accepts one decoded instruction and its operands over a valid/ready handshake, and drives the ALU's one-hot opcode enable, type, funct3 enable, funct7 and operand ports. It runs single-cycle ALU ops directly and sequences RV32M `MUL` as a 32-iteration shift-add loop on the ALU adder. Results go to writeback over a second valid/ready handshake.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: decode offers an instruction.
- `in_ready` output 1: controller accepts this cycle.
- `in_inst` input 32: raw instruction word.
- `in_src1` input 32: rs1 value or PC, resolved upstream.
- `in_src2` input 32: rs2 value or immediate, resolved upstream.
- `in_rd_addr` input 5: destination register.
- `alu_en` output 32: one-hot opcode enable, bit = `inst[6:2]`.
- `alu_type` output 3: instruction format.
- `alu_funct3_en` output 8: one-hot funct3.
- `alu_funct7` output 7: funct7 field.
- `alu_src1` output 32: ALU operand 1.
- `alu_src2` output 32: ALU operand 2.
- `alu_rd` input 32: ALU result, combinational from the `alu_*` outputs.
- `out_valid` output 1: result available.
- `out_ready` input 1: writeback accepts.
- `out_data` output 32: result.
- `out_rd_addr` output 5: destination register.
- `out_wen` output 1: register write required.
- `out_illegal` output 1: instruction rejected.

## Operation
- **States:** IDLE, ALU, MUL, DONE.
- **Handshake:** `in_ready` = (IDLE) or (DONE and `out_ready`). On `in_valid & in_ready`, latch inst, operands and rd, then decode:
  - `inst[1:0]` ≠ 2'b11 (RV32C) → DONE with illegal.
  - Unknown opcode → DONE with illegal.
  - funct7 = 7'b0000001 with opcode OP and funct3 = 000 → MUL.
  - funct7 = 7'b0000001 with opcode OP and any other funct3 → DONE with illegal.
  - Otherwise → ALU.
- **Opcode to type:** R=0 (OP 01100); I=1 (OP-IMM 00100, LOAD 00000, JALR 11001); S=2 (STORE 01000); B=3 (BRANCH 11000); U=4 (LUI 01101, AUIPC 00101); J=5 (JAL 11011).
- **Field decode:**
  - `alu_funct3_en` = one-hot of `inst[14:12]` for types R/I/S/B, 0 for U/J.
  - `alu_funct7` = `inst[31:25]` for R, and for OP-IMM with funct3 001/101; 0 otherwise.
- **ALU state:** drive the decoded fields plus the latched src1/src2. Capture `alu_rd` into `out_data` and go to DONE.
- **MUL state:**
  - ALU forced to ADD: `alu_en` bit 12, type R, funct3_en 8'h01, funct7 0.
  - `alu_src1` = acc; `alu_src2` = mplier[0] ? mcand : 0.
  - Each cycle: acc ← `alu_rd`, mcand ← mcand<<1, mplier ← mplier>>1, cnt++.
  - Initial values: acc=0, mcand=src1, mplier=src2, cnt=0.
  - Fixed 32 iterations, no early exit. Low 32 bits of the product go to `out_data`.
- **DONE state:**
  - `out_valid`=1; outputs stay stable until `out_ready`.
  - `out_wen` = legal & (OP | OP-IMM | LUI | AUIPC) & rd ≠ 0.
  - Illegal: `out_data`=0, `out_wen`=0, `out_illegal`=1.
- **Idle drive:** in IDLE and DONE, all `alu_*` outputs are 0. `alu_en`=0 gates the ALU.

## Timing
- **Reset:** state IDLE; `out_valid`, `out_data`, `out_rd_addr`, `out_wen`, `out_illegal` and all `alu_*` = 0; acc, cnt, mcand and mplier = 0. `in_ready`=1 after reset.
- **Reset mid-operation:** asserting `rst_n` low in ALU, MUL or DONE aborts the operation with no output.
- **Latency, accept at edge 0:**
  - ALU op: `out_valid` from cycle 2.
  - MUL: MUL state in cycles 1..32, `out_valid` from cycle 33.
  - Illegal: `out_valid` from cycle 1.
- **Backpressure:** DONE holds indefinitely while `out_ready`=0, with outputs unchanged.
- **Simultaneous retire and accept:** DONE & `out_ready` & `in_valid` retires the old result and latches the new instruction on the same edge. Peak throughput is one ALU op per 2 cycles.
- **Counter:** cnt is 5 bits and wraps 31→0 on the exit edge of MUL.

## Structure
- **Package `ysyx_23060062_exu_pkg`:**
  - 5-bit opcode constants.
  - `alu_type` encodings R..J.
  - State enum.
  - MULDIV funct7 constant.
  - ADD op field constants.
- **Sub-module `ysyx_23060062_exu_decode`:** combinational, maps inst to en, type, funct3_en, funct7, is_mul and illegal.
- **ALU:** instantiated at the EXU top, not inside this block.

## Test plan
- **ADD:** `add x3,x1,x2` (0x002081B3), src1=5, src2=7, `out_ready`=1 → cycle 2: `out_data`=12, rd=3, wen=1, illegal=0.
- **MUL:** `mul x5,x1,x2` (0x022082B3), src1=0xFFFFFFFF, src2=3 → exactly 32 MUL cycles, `out_valid` at cycle 33, `out_data`=0xFFFFFFFD.
- **Illegal, unsupported M op:** `mulh` (0x022092B3) → cycle 1 `out_illegal`=1, wen=0, data=0. Compressed 0x00004501 → same response.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0. Then raise `out_ready` with `in_valid`=1 → retire and accept on the same edge.
- **Reset mid-MUL:** pull `rst_n` low at MUL cycle 10 → outputs 0 and state IDLE immediately. After release, the next ADD completes normally.
- **Write enable rules:** `add x0,x1,x2` → wen=0. `sw` → result equals `src1+src2`, wen=0, type=2.
